// File: rtl/difftest_step_ctrl_if.sv
// Host command, packet/credit and status signals of the difftest step controller.
// Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready are both high.
interface difftest_step_ctrl_if #(
  parameter int STEP_W = 32,
  parameter int CNT_W  = 5
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_free;
  logic              halt_req;
  logic              pkt_valid;
  logic              credit_ret;
  logic              data_next;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] steps_left;
  logic [CNT_W-1:0]  credits;
  logic              err;
  logic [31:0]       perf_run;
  logic [31:0]       perf_stall;
  logic              state_dbg;

  modport master (
    output cmd_valid, cmd_steps, cmd_free, halt_req, pkt_valid, credit_ret,
    input  cmd_ready, data_next, busy, done, steps_left, credits, err,
           perf_run, perf_stall, state_dbg
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_free, halt_req, pkt_valid, credit_ret,
    output cmd_ready, data_next, busy, done, steps_left, credits, err,
           perf_run, perf_stall, state_dbg
  );
endinterface

// File: rtl/difftest_step_ctrl.sv
// Step/free-run clock-enable generator with downstream packet credit tracking.
// Optional perf counters are built when DIFFTEST_STEP_PERF_EN is defined.
module difftest_step_ctrl #(
  parameter int STEP_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input logic clock,
  input logic reset,
  difftest_step_ctrl_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [0:0]        state, state_next;
  logic              free_q, free_next;
  logic [STEP_W-1:0] steps_q, st_next;
  logic [CNT_W-1:0]  cr_q, cr_next;
  logic [CNT_W:0]    cr_sum;
  logic              dn_q, dn_next;
  logic              done_q, done_next;
  logic              err_q, err_next;
  logic              accept, zero_cmd, consume, overflow;

  always_comb begin
    accept   = (state == IDLE) && bus.cmd_valid;
    zero_cmd = !bus.cmd_free && (bus.cmd_steps == '0);
    consume  = bus.pkt_valid && dn_q;
    overflow = bus.credit_ret && (cr_q == FULL);

    cr_sum = {1'b0, cr_q} - (CNT_W+1)'(consume) + (CNT_W+1)'(bus.credit_ret);
    // A return at full is an error; the count never rises above DEPTH.
    cr_next = (cr_sum > {1'b0, FULL}) ? FULL : cr_sum[CNT_W-1:0];

    if (accept) begin
      st_next   = bus.cmd_steps;
      free_next = bus.cmd_free;
    end else begin
      st_next   = (free_q || steps_q == '0) ? steps_q : steps_q - STEP_W'(dn_q);
      free_next = free_q;
    end

    state_next = state;
    if (state == IDLE) begin
      if (accept && !zero_cmd) state_next = RUN;
    end else if (bus.halt_req || (!free_q && st_next == '0)) begin
      state_next = IDLE;
    end

    // Requiring a credit for the next enable covers the packet that may be in flight now.
    dn_next   = (state_next == RUN) && (free_next || st_next != '0) && (cr_next != '0);
    done_next = ((state == RUN) && (state_next == IDLE)) || (accept && zero_cmd);
    err_next  = err_q || overflow || (bus.pkt_valid && !dn_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      free_q  <= 1'b0;
      steps_q <= '0;
      cr_q    <= FULL;
      dn_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      free_q  <= free_next;
      steps_q <= st_next;
      cr_q    <= cr_next;
      dn_q    <= dn_next;
      done_q  <= done_next;
      err_q   <= err_next;
    end
  end

`ifdef DIFFTEST_STEP_PERF_EN
  logic [31:0] run_q, stall_q;

  always_ff @(posedge clock) begin
    if (reset || accept) begin
      run_q   <= '0;
      stall_q <= '0;
    end else begin
      if (dn_q && run_q != '1) run_q <= run_q + 32'd1;
      if (state == RUN && !dn_q && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.perf_run   = run_q;
  assign bus.perf_stall = stall_q;
`else
  assign bus.perf_run   = '0;
  assign bus.perf_stall = '0;
`endif

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.data_next  = dn_q;
  assign bus.busy       = (state == RUN);
  assign bus.done       = done_q;
  assign bus.steps_left = steps_q;
  assign bus.credits    = cr_q;
  assign bus.err        = err_q;
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_difftest_step_ctrl.sv
// Directed bench for difftest_step_ctrl: stepping, credits, halt, errors and reset.
module tb_difftest_step_ctrl;
  logic clock;
  logic reset;
  logic pkt_force;
  logic pkt_follow;
  int   tests;
  int   fails;

  difftest_step_ctrl_if #(.STEP_W(32), .CNT_W(5)) bus ();

  difftest_step_ctrl #(.STEP_W(32), .DEPTH(16), .CNT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Packet source that emits on every enabled cycle when pkt_follow is set.
  assign bus.pkt_valid = pkt_force | (pkt_follow & bus.data_next);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic send_cmd(input logic [31:0] steps, input logic free);
    bus.cmd_valid = 1'b1;
    bus.cmd_steps = steps;
    bus.cmd_free  = free;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.data_next !== 1'b0) begin fails++; $display("FAIL reset_data_next got %0d want 0", bus.data_next); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0d want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %0d want 0", bus.done); end
    tests++; if (bus.steps_left !== 32'd0) begin fails++; $display("FAIL reset_steps_left got %0d want 0", bus.steps_left); end
    tests++; if (bus.credits !== 5'd16) begin fails++; $display("FAIL reset_credits got %0d want 16", bus.credits); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err got %0d want 0", bus.err); end
    tests++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got %0d want 1", bus.cmd_ready); end
    tests++; if (bus.perf_run !== 32'd0 || bus.perf_stall !== 32'd0) begin fails++; $display("FAIL reset_perf got %0d/%0d want 0/0", bus.perf_run, bus.perf_stall); end
  endtask

  task automatic test_steps();
    int n_en;
    int n_done;
    int first_en;
    int done_at;
    n_en = 0; n_done = 0; first_en = -1; done_at = -1;
    send_cmd(32'd5, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (bus.data_next === 1'b1) begin
        n_en++;
        if (first_en < 0) first_en = i;
      end
      if (bus.done === 1'b1) begin
        n_done++;
        done_at = i;
      end
      tick();
    end
    tests++; if (first_en !== 0) begin fails++; $display("FAIL steps_first_enable got %0d want 0", first_en); end
    tests++; if (n_en !== 5) begin fails++; $display("FAIL steps_enabled_cycles got %0d want 5", n_en); end
    tests++; if (n_done !== 1 || done_at !== 5) begin fails++; $display("FAIL steps_done got count %0d at %0d want 1 at 5", n_done, done_at); end
    tests++; if (bus.steps_left !== 32'd0) begin fails++; $display("FAIL steps_left_end got %0d want 0", bus.steps_left); end
    tests++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL steps_idle got ready %0d busy %0d want 1 0", bus.cmd_ready, bus.busy); end
  endtask

  task automatic test_credit_stall();
    int n_en;
    n_en = 0;
    pkt_follow = 1'b1;
    send_cmd(32'd0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      if (bus.data_next === 1'b1) n_en++;
      tick();
    end
    tests++; if (n_en !== 16) begin fails++; $display("FAIL credit_enabled_cycles got %0d want 16", n_en); end
    tests++; if (bus.credits !== 5'd0 || bus.busy !== 1'b1 || bus.data_next !== 1'b0) begin
      fails++; $display("FAIL credit_stall got credits %0d busy %0d dn %0d want 0 1 0", bus.credits, bus.busy, bus.data_next);
    end
    bus.credit_ret = 1'b1;
    tick();
    bus.credit_ret = 1'b0;
    n_en = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.data_next === 1'b1) n_en++;
      tick();
    end
    tests++; if (n_en !== 1) begin fails++; $display("FAIL credit_resume_cycles got %0d want 1", n_en); end
    tests++; if (bus.credits !== 5'd0 || bus.err !== 1'b0) begin fails++; $display("FAIL credit_after_resume got credits %0d err %0d want 0 0", bus.credits, bus.err); end
`ifdef DIFFTEST_STEP_PERF_EN
    tests++; if (bus.perf_run !== 32'd17) begin fails++; $display("FAIL perf_run_credit got %0d want 17", bus.perf_run); end
`endif
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    pkt_follow = 1'b0;
    tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin fails++; $display("FAIL credit_halt got busy %0d done %0d want 0 1", bus.busy, bus.done); end
    bus.credit_ret = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    bus.credit_ret = 1'b0;
    tests++; if (bus.credits !== 5'd16 || bus.err !== 1'b0) begin fails++; $display("FAIL credit_refill got credits %0d err %0d want 16 0", bus.credits, bus.err); end
  endtask

  task automatic test_zero_cmd();
    int n_en;
    int n_done;
    n_en = 0; n_done = 0;
    send_cmd(32'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (bus.data_next === 1'b1) n_en++;
      if (bus.done === 1'b1) n_done++;
      if (i == 0) begin
        tests++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL zero_done_pulse got done %0d busy %0d want 1 0", bus.done, bus.busy); end
      end
      tick();
    end
    tests++; if (n_en !== 0 || n_done !== 1) begin fails++; $display("FAIL zero_cmd got enables %0d dones %0d want 0 1", n_en, n_done); end
  endtask

  task automatic test_halt();
    int n_en;
    n_en = 0;
    send_cmd(32'd3, 1'b1);
    for (int i = 1; i < 10; i++) begin
      if (bus.data_next === 1'b1) n_en++;
      tick();
    end
    tests++; if (n_en !== 9 || bus.data_next !== 1'b1) begin fails++; $display("FAIL halt_freerun got enables %0d dn %0d want 9 1", n_en, bus.data_next); end
    n_en++;
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    tests++; if (bus.data_next !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL halt_stop got dn %0d done %0d busy %0d want 0 1 0", bus.data_next, bus.done, bus.busy);
    end
`ifdef DIFFTEST_STEP_PERF_EN
    tests++; if (bus.perf_run !== n_en || bus.perf_stall !== 32'd0) begin fails++; $display("FAIL perf_halt got %0d/%0d want %0d/0", bus.perf_run, bus.perf_stall, n_en); end
`endif
    tick();
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL halt_done_width got %0d want 0", bus.done); end
    bus.halt_req = 1'b1;
    tick();
    tick();
    bus.halt_req = 1'b0;
    tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL halt_idle_ignored got busy %0d done %0d ready %0d want 0 0 1", bus.busy, bus.done, bus.cmd_ready);
    end
  endtask

  task automatic test_err();
    bus.credit_ret = 1'b1;
    tick();
    bus.credit_ret = 1'b0;
    tests++; if (bus.err !== 1'b1 || bus.credits !== 5'd16) begin fails++; $display("FAIL err_overflow got err %0d credits %0d want 1 16", bus.err, bus.credits); end
    tick();
    tick();
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL err_sticky got %0d want 1", bus.err); end
    do_reset();
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL err_cleared got %0d want 0", bus.err); end
    pkt_force = 1'b1;
    tick();
    pkt_force = 1'b0;
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL err_pkt_idle got %0d want 1", bus.err); end
    do_reset();
  endtask

  task automatic test_reset_mid_run();
    send_cmd(32'd100, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    tests++; if (bus.steps_left !== 32'd95 || bus.busy !== 1'b1) begin fails++; $display("FAIL midrun_steps got %0d busy %0d want 95 1", bus.steps_left, bus.busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (bus.data_next !== 1'b0 || bus.steps_left !== 32'd0 || bus.credits !== 5'd16 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL midrun_reset got dn %0d steps %0d credits %0d busy %0d want 0 0 16 0",
                        bus.data_next, bus.steps_left, bus.credits, bus.busy);
    end
    tests++; if (bus.perf_run !== 32'd0) begin fails++; $display("FAIL midrun_perf_run got %0d want 0", bus.perf_run); end
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    reset          = 1'b1;
    pkt_force      = 1'b0;
    pkt_follow     = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_steps  = '0;
    bus.cmd_free   = 1'b0;
    bus.halt_req   = 1'b0;
    bus.credit_ret = 1'b0;
    test_reset();
    test_steps();
    test_credit_stall();
    test_zero_cmd();
    test_halt();
    test_err();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/difftest_step_ctrl.md
Name: difftest_step_ctrl

Overview:
Generates the registered `data_next` clock-enable that gates the SoC, device and timer clocks in the FPGA difftest build. Runs the SoC for a host-commanded number of enabled cycles, or free-runs until halted. Tracks credits for the downstream difftest packet buffer so that no packet is produced while the buffer is full. Sits between the host command path and the clock-gating block, in the free-running fabric clock domain.

Parameters:
STEP_W, 32, width of step count and steps_left
DEPTH, 16, downstream buffer entries; initial credit count
CNT_W, 5, credit counter width (must hold DEPTH)

Ports:
clock  in  1  free-running fabric clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_steps  in  STEP_W  enabled-cycle budget
cmd_free  in  1  free-run; cmd_steps ignored
halt_req  in  1  stop running (level, sampled each cycle)
pkt_valid  in  1  DUT emitted one difftest packet this cycle
credit_ret  in  1  downstream freed one entry
data_next  out  1  clock enable to gating block (registered)
busy  out  1  state==RUN
done  out  1  one-cycle pulse on RUN->IDLE
steps_left  out  STEP_W  remaining budget
credits  out  CNT_W  free downstream entries
err  out  1  sticky protocol error
perf_run  out  32  enabled-cycle count (optional feature)
perf_stall  out  32  credit-stall count (optional feature)

Behaviour:
- Interface decision: one clock (`clock`); reset (`reset`) is synchronous and active-high.
- Reset values:
  - data_next=0, busy=0, done=0, steps_left=0, credits=DEPTH, err=0, perf counters=0, state=IDLE.
  - The gating block forces clocks on during reset on its own; this block does not.
- States: IDLE, RUN.
- cmd_ready:
  - cmd_ready=1 only in IDLE.
  - On accept: steps_left<=cmd_steps and free<=cmd_free.
  - Go to RUN unless cmd_free=0 and cmd_steps=0. In that case stay IDLE and pulse done next cycle.
- Credit arithmetic, per cycle:
  - cr_next = credits - (pkt_valid&data_next) + credit_ret.
  - Simultaneous consume and return leaves credits unchanged.
  - credit_ret while credits==DEPTH: set err, saturate at DEPTH.
- Step arithmetic:
  - st_next = steps_left - data_next when not free; unchanged when free.
  - No wrap below 0.
- data_next register:
  - data_next <= (state_next==RUN) & (free | st_next!=0) & (cr_next>=1).
  - The cr_next>=1 check covers the single in-flight cycle, so credits never go negative.
- RUN->IDLE transitions:
  - On halt_req=1, or when not free and st_next==0.
  - data_next is 0 from the following cycle.
  - done=1 for exactly that one cycle.
  - halt_req in IDLE is ignored.
- Credit stall:
  - In RUN with cr_next==0: data_next=0, stay in RUN.
  - Resume the cycle after credit_ret.
- err (sticky until reset):
  - pkt_valid while data_next=0.
  - credit_ret overflow.
- reset mid-RUN: immediate return to reset values next cycle; in-flight steps discarded.

Optional Feature:
DIFFTEST_STEP_PERF_EN
- Defined:
  - perf_run increments each cycle with data_next=1.
  - perf_stall increments each cycle in RUN with data_next=0.
  - Both saturate at 2^32-1 and clear on reset or on command accept.
- Undefined: perf_run and perf_stall are tied to 0 and no counter logic is built.

Test Plan:
- Reset, then cmd_steps=5, cmd_free=0, no pkt_valid -> data_next high exactly 5 cycles starting 1 cycle after accept; done pulses once; steps_left=0; cmd_ready returns to 1.
- DEPTH=16, cmd_free=1, pkt_valid on every enabled cycle, no credit_ret -> exactly 16 enabled cycles, then data_next=0 with credits=0 and busy=1; one credit_ret -> exactly one more enabled cycle.
- cmd_steps=0, cmd_free=0 -> stays IDLE, data_next never asserts, done pulses once.
- Free-run, halt_req asserted on cycle 10 -> data_next=0 from cycle 11, done=1 on cycle 11, state IDLE.
- credit_ret at credits=16 -> err=1 and held; credits stays 16. Separately, pkt_valid while data_next=0 -> err=1.
- reset asserted mid-RUN with steps_left=100 -> next cycle data_next=0, steps_left=0, credits=16; with DIFFTEST_STEP_PERF_EN, perf_run reads 0.
